bank_access_ctrl: RTL

Sequencer and arbiter in front of the 16x3 counter register bank of the VGA test design.
- Grants bank access to two increment requesters (round-robin).
- Performs each increment as a two-cycle read-modify-write.
- Runs a full clear sweep on request, and otherwise lends the read port to the VGA display scanner.
- Replaces ad-hoc clock division with an internal issue-rate tick, so the whole block runs on clk.

---
 rtl/bank_access_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bank_access_ctrl.sv
// Arbiter and read-modify-write sequencer in front of the 16x3 counter bank.
// Grants round-robin increments, runs clear sweeps and lends the read port to the display.
module bank_access_ctrl #(
  parameter int BIT_ADDR = 4,
  parameter int BIT_DATO = 3,
  parameter int TICK_DIV = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic [BIT_ADDR-1:0] addr0,
  output logic                gnt0,
  input  logic                req1,
  input  logic [BIT_ADDR-1:0] addr1,
  output logic                gnt1,
  input  logic                clr_req,
  output logic                clr_gnt,
  output logic                clr_done,
  output logic                op_done,
  input  logic [BIT_ADDR-1:0] disp_addr,
  output logic [BIT_DATO-1:0] disp_rdata,
  output logic                disp_valid,
  output logic [BIT_ADDR-1:0] bank_addr_r,
  input  logic [BIT_DATO-1:0] bank_rdata,
  output logic [BIT_ADDR-1:0] bank_addr_w,
  output logic [BIT_DATO-1:0] bank_wdata,
  output logic                bank_we
);

  typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

  logic tick;

  generate
    if (TICK_DIV == 0) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      logic [TICK_DIV-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_q + 1'b1;
      end
      assign tick = &cnt_q;
    end
  endgenerate

  state_t              state_q, state_d;
  logic [BIT_ADDR-1:0] addr_q, addr_d;
  logic [BIT_DATO-1:0] data_q, data_d;
  logic [BIT_ADDR-1:0] idx_q, idx_d;
  logic                rr_q, rr_d;       // 1: requester 1 was granted last
  logic [BIT_ADDR-1:0] wa_q, wa_d;
  logic [BIT_DATO-1:0] wd_q, wd_d;
  logic [BIT_DATO-1:0] disp_rdata_q, disp_rdata_d;
  logic                disp_valid_q, disp_valid_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    idx_d        = idx_q;
    rr_d         = rr_q;
    wa_d         = wa_q;
    wd_d         = wd_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    clr_gnt      = 1'b0;
    clr_done     = 1'b0;
    op_done      = 1'b0;
    bank_we      = 1'b0;
    bank_addr_w  = wa_q;
    bank_wdata   = wd_q;
    bank_addr_r  = disp_addr;

    unique case (state_q)
      IDLE: begin
        // Grants are combinational, so keep them quiet while reset is held.
        if (tick && rst) begin
          if (clr_req) begin
            clr_gnt = 1'b1;
            idx_d   = '0;
            state_d = CLR;
          end else if (req0 && (!req1 || rr_q)) begin
            gnt0    = 1'b1;
            addr_d  = addr0;
            rr_d    = 1'b0;
            state_d = RD;
          end else if (req1) begin
            gnt1    = 1'b1;
            addr_d  = addr1;
            rr_d    = 1'b1;
            state_d = RD;
          end
        end
      end
      RD: begin
        bank_addr_r = addr_q;
        data_d      = bank_rdata;
        state_d     = WR;
      end
      WR: begin
        bank_we     = 1'b1;
        bank_addr_w = addr_q;
        bank_wdata  = data_q + 1'b1;
        wa_d        = addr_q;
        wd_d        = data_q + 1'b1;
        op_done     = 1'b1;
        state_d     = IDLE;
      end
      CLR: begin
        bank_we     = 1'b1;
        bank_addr_w = idx_q;
        bank_wdata  = '0;
        wa_d        = idx_q;
        wd_d        = '0;
        idx_d       = idx_q + 1'b1;
        if (idx_q == {BIT_ADDR{1'b1}}) begin
          clr_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The read port belongs to the display except during the increment read.
    disp_rdata_d = (state_q == RD) ? disp_rdata_q : bank_rdata;
    disp_valid_d = (state_q != RD);
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      rr_q         <= 1'b1;
      wa_q         <= '0;
      wd_q         <= '0;
      disp_rdata_q <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      rr_q         <= rr_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      disp_rdata_q <= disp_rdata_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign disp_rdata = disp_rdata_q;
  assign disp_valid = disp_valid_q;

endmodule
